// File: rtl/uart_tx_queue_pkg.sv
// Shared constants for the UART transmit queue.
// Frame layout: bits [7:0] data, bit 8 frame bit (parity or extra mark).
package uart_tx_queue_pkg;

  localparam int FRAME_W = 9;

  typedef logic [FRAME_W-1:0] frame_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam frame_t IDLE_MARK = 9'h1FF;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Single-clock byte FIFO with registered full/empty/count.
// Pointers wrap naturally; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_nxt;

  assign wr_ok   = wr & ~full;
  assign rd_ok   = rd & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      full  <= (count_nxt == CNT_MAX);
      empty <= (count_nxt == CNT_ZERO);
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue and go/done sequencer for the UART transmitter.
// Optional UART_TX_QUEUE_PARITY_EN: bit 8 carries even parity, else a mark.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_en,
  input  logic [7:0]                  i_wr_data,
  input  logic                        i_clr_ovf,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH+1)-1:0]  o_count,
  output logic                        o_overflow,
  output logic                        o_busy,
  output logic                        o_tx_go,
  output logic [8:0]                  o_tx_data,
  input  logic                        i_tx_done
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       done_q;
  logic       done_rise;
  logic [7:0] gap_cnt;
  logic       fifo_rd;
  logic [7:0] head;
  logic       frame_bit;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .wr      (i_wr_en),
    .wr_data (i_wr_data),
    .rd      (fifo_rd),
    .rd_data (head),
    .full    (o_full),
    .empty   (o_empty),
    .count   (o_count)
  );

`ifdef UART_TX_QUEUE_PARITY_EN
  assign frame_bit = ^head;
`else
  assign frame_bit = 1'b1;
`endif

  // A done level held across many cycles must only complete one byte.
  assign done_rise = i_tx_done & ~done_q;

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!o_empty) begin
          fifo_rd   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      o_busy     <= 1'b0;
      o_tx_go    <= 1'b0;
      o_tx_data  <= IDLE_MARK;
      done_q     <= 1'b0;
      gap_cnt    <= '0;
      o_overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_busy  <= (state_nxt != ST_IDLE);
      o_tx_go <= fifo_rd;
      done_q  <= i_tx_done;
      if (fifo_rd) begin
        o_tx_data <= {frame_bit, head};
      end
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (i_wr_en && o_full) begin
        o_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        o_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: vector table plus multi-cycle sequences.
// Second instance runs with a 4-cycle inter-byte gap.
module tb_uart_tx_queue;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       ovf;
  logic       busy;
  logic       go;
  logic [8:0] data;
  logic       done;

  logic       g_wr_en;
  logic [7:0] g_wr_data;
  logic       g_clr_ovf;
  logic       g_full;
  logic       g_empty;
  logic [3:0] g_count;
  logic       g_ovf;
  logic       g_busy;
  logic       g_go;
  logic [8:0] g_data;
  logic       g_done;

  int total = 0;
  int bad   = 0;

  uart_tx_queue #(.DEPTH(8), .GAP_CYCLES(0)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_clr_ovf  (clr_ovf),
    .o_full     (full),
    .o_empty    (empty),
    .o_count    (count),
    .o_overflow (ovf),
    .o_busy     (busy),
    .o_tx_go    (go),
    .o_tx_data  (data),
    .i_tx_done  (done)
  );

  uart_tx_queue #(.DEPTH(8), .GAP_CYCLES(4)) dut_g (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wr_en    (g_wr_en),
    .i_wr_data  (g_wr_data),
    .i_clr_ovf  (g_clr_ovf),
    .o_full     (g_full),
    .o_empty    (g_empty),
    .o_count    (g_count),
    .o_overflow (g_ovf),
    .o_busy     (g_busy),
    .o_tx_go    (g_go),
    .o_tx_data  (g_data),
    .i_tx_done  (g_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] frm(input logic [7:0] b);
`ifdef UART_TX_QUEUE_PARITY_EN
    return {^b, b};
`else
    return {1'b1, b};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0; done = 1'b0;
    g_wr_en = 1'b0; g_wr_data = '0; g_clr_ovf = 1'b0; g_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       dn;
    logic       e_go;
    logic [8:0] e_data;
    logic [3:0] e_cnt;
    logic       e_empty;
    logic       e_busy;
  } vec_t;

  vec_t vt[6];
  logic [7:0] hello [5];
  int n;
  int done_at;
  int gt [4];

  initial begin
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    vt[0] = '{1'b1, 8'h48, 1'b0, 1'b0, 9'h1FF,    4'd1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, frm(8'h48), 4'd0, 1'b1, 1'b1};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, frm(8'h48), 4'd0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, frm(8'h48), 4'd0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, frm(8'h48), 4'd0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, frm(8'h48), 4'd0, 1'b1, 1'b0};

    // reset state
    do_reset();
    chk("rst_go", go, 0);
    chk("rst_data", data, 9'h1FF);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // single byte via vector table
    for (int i = 0; i < 6; i++) begin
      wr_en = vt[i].wr; wr_data = vt[i].d; done = vt[i].dn;
      tick();
      chk($sformatf("vec%0d_go", i), go, vt[i].e_go);
      chk($sformatf("vec%0d_data", i), data, vt[i].e_data);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_empty", i), empty, vt[i].e_empty);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
    end
    wr_en = 1'b0; done = 1'b0;

    // "Hello" with done 10 cycles after each go
    do_reset(); rst = 1'b0;
    n = 0; done_at = -1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      wr_en = 1'b0;
      if (cyc < 5) begin
        wr_en = 1'b1; wr_data = hello[cyc];
      end
      done = (cyc == done_at);
      tick();
      if (go) begin
        if (n < 5) chk($sformatf("hello_data%0d", n), data, frm(hello[n]));
        if (done_at >= 0) chk("hello_next_go", cyc + 1, done_at + 2);
        else chk("hello_first_go", cyc + 1, 2);
        done_at = cyc + 11;
        n++;
      end
    end
    wr_en = 1'b0; done = 1'b0;
    chk("hello_n_go", n, 5);
    chk("hello_empty", empty, 1);
    chk("hello_busy", busy, 0);

    // stalled transmitter, overflow handling
    do_reset(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'h30 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("stall_count", count, 8);
    chk("stall_full", full, 1);
    chk("stall_ovf", ovf, 1);
    chk("stall_busy", busy, 1);
    chk("stall_data", data, frm(8'h30));
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);
    chk("clr_count", count, 8);
    wr_en = 1'b1; wr_data = 8'hEE; clr_ovf = 1'b1;
    tick();
    wr_en = 1'b0; clr_ovf = 1'b0;
    chk("set_wins_ovf", ovf, 1);
    chk("set_wins_count", count, 8);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("clr2_ovf", ovf, 0);
    done = 1'b1; tick(); done = 1'b0;
    chk("stall_done_busy", busy, 0);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    chk("pop_drop_go", go, 1);
    chk("pop_drop_data", data, frm(8'h31));
    chk("pop_drop_count", count, 7);
    chk("pop_drop_ovf", ovf, 1);
    chk("pop_drop_full", full, 0);

    // done held high for 20 cycles
    do_reset(); rst = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      wr_en = (cyc < 2);
      wr_data = 8'h11 + 8'(cyc);
      done = (cyc >= 3 && cyc < 23) || (cyc == 25);
      tick();
      if (go) begin
        if (n < 4) gt[n] = cyc + 1;
        n++;
      end
      if (cyc + 1 == 24) chk("held_busy_mid", busy, 1);
      if (cyc + 1 == 26) chk("held_busy_end", busy, 0);
    end
    wr_en = 1'b0; done = 1'b0;
    chk("held_n_go", n, 2);
    chk("held_go0", gt[0], 2);
    chk("held_go1", gt[1], 5);
    chk("held_data", data, frm(8'h12));

    // reset during WAIT with 3 bytes queued
    do_reset(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'hA0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_busy", busy, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_go", go, 0);
    chk("arst_data", data, 9'h1FF);
    chk("arst_count", count, 0);
    chk("arst_busy", busy, 0);
    tick(); rst = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (go) n++;
    end
    chk("arst_no_go", n, 0);

    // reset while go is high
    wr_en = 1'b1; wr_data = 8'h5A; tick(); wr_en = 1'b0;
    tick();
    chk("go_before_rst", go, 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_go_pulse", go, 0);
    chk("arst_go_data", data, 9'h1FF);
    tick(); rst = 1'b0;

    // GAP_CYCLES=4 instance
    do_reset(); rst = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      g_wr_en = (cyc < 2);
      g_wr_data = 8'h70 + 8'(cyc);
      g_done = (cyc == 12) || (cyc == 14);
      tick();
      if (g_go) begin
        if (n < 4) gt[n] = cyc + 1;
        n++;
      end
      if (cyc + 1 == 16) chk("gap_busy", g_busy, 1);
    end
    g_wr_en = 1'b0; g_done = 1'b0;
    chk("gap_n_go", n, 2);
    chk("gap_go0", gt[0], 2);
    chk("gap_go1", gt[1], 18);
    chk("gap_data", g_data, frm(8'h71));
    chk("gap_busy_end", g_busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
